// File: rtl/chacha_stream_xor.sv
// ChaCha keystream XOR streamer.
// Requests 512-bit keystream blocks from an external chacha_core and XORs
// them, 64 bits at a time (MSB word first), onto a ready/valid plaintext
// stream. The output register drains independently of block refills.
module chacha_stream_xor (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   output logic         core_init,
   output logic         core_next,
   input  logic         core_ready,
   input  logic [511:0] core_data_out,
   input  logic         core_data_out_valid,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [63:0]  in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  out_data,
   output logic         out_last,
   output logic         busy,
   output logic         done,
   output logic [15:0]  blocks_used
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_WAIT   = 2'd2,
      ST_STREAM = 2'd3
   } state_t;

   state_t         state_r;
   state_t         state_nxt_s;
   logic           first_r;
   logic           wait_first_r;
   logic [2:0]     idx_r;
   logic [511:0]   buf_r;
   logic           core_init_r;
   logic           core_next_r;
   logic           out_valid_r;
   logic [63:0]    out_data_r;
   logic           out_last_r;
   logic           done_r;
   logic [15:0]    blocks_r;

   logic           start_s;
   logic           issue_s;
   logic           latch_s;
   logic           finish_s;
   logic           in_xfer_s;
   logic           out_xfer_s;
   logic           in_ready_s;
   logic [63:0]    word_s;

   // Word k sits at buf_r[511-64k -: 64]; its low bit index is 64*(7-k) = {~k, 6'b0}.
   assign word_s     = buf_r[{~idx_r, 6'd0} +: 64];
   assign in_ready_s = (state_r == ST_STREAM) && (!out_valid_r || out_ready);
   assign in_xfer_s  = in_valid && in_ready_s;
   assign out_xfer_s = out_valid_r && out_ready;
   assign start_s    = (state_r == ST_IDLE) && start;

   assign in_ready    = in_ready_s;
   assign core_init   = core_init_r;
   assign core_next   = core_next_r;
   assign out_valid   = out_valid_r;
   assign out_data    = out_data_r;
   assign out_last    = out_last_r;
   assign done        = done_r;
   assign blocks_used = blocks_r;
   assign busy        = (state_r != ST_IDLE);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode and one-cycle control strobes.
   always_comb begin
      state_nxt_s = state_r;
      issue_s     = 1'b0;
      latch_s     = 1'b0;
      finish_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_REQ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (core_ready) begin
               issue_s     = 1'b1;
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            // The first WAIT cycle is the pulse cycle; a valid seen then is stale.
            if (!wait_first_r && core_ready && core_data_out_valid) begin
               latch_s     = 1'b1;
               state_nxt_s = ST_STREAM;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_STREAM: begin
            if (in_xfer_s) begin
               if (in_last) begin
                  finish_s    = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else if (idx_r == 3'd7) begin
                  state_nxt_s = ST_REQ;
               end else begin
                  state_nxt_s = ST_STREAM;
               end
            end else begin
               state_nxt_s = ST_STREAM;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Core handshake: init/next pulses, first-block flag, block counter, stale guard.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         core_init_r  <= 1'b0;
         core_next_r  <= 1'b0;
         first_r      <= 1'b1;
         wait_first_r <= 1'b0;
         blocks_r     <= 16'd0;
      end else begin
         core_init_r  <= issue_s && first_r;
         core_next_r  <= issue_s && !first_r;
         wait_first_r <= issue_s;
         if (start_s) begin
            first_r  <= 1'b1;
            blocks_r <= 16'd0;
         end else if (issue_s) begin
            first_r  <= 1'b0;
            blocks_r <= blocks_r + 16'd1;
         end
      end
   end

   // Keystream buffer and word index.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_r <= 512'd0;
         idx_r <= 3'd0;
      end else if (latch_s) begin
         buf_r <= core_data_out;
         idx_r <= 3'd0;
      end else if (in_xfer_s) begin
         idx_r <= idx_r + 3'd1;
      end
   end

   // Output register: loads on input transfer, clears on drain, otherwise holds.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= 64'd0;
         out_last_r  <= 1'b0;
      end else if (in_xfer_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= in_data ^ word_s;
         out_last_r  <= in_last;
      end else if (out_xfer_s) begin
         out_valid_r <= 1'b0;
      end
   end

   // End-of-message pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done_r <= 1'b0;
      end else begin
         done_r <= finish_s;
      end
   end

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Self-checking bench for chacha_stream_xor with a behavioural chacha_core model.
// The core model holds a stale valid (with garbage data) through each pulse
// cycle, so every block request also exercises the stale-valid guard.
module tb_chacha_stream_xor;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic         core_init;
   logic         core_next;
   logic         core_ready;
   logic [511:0] core_data_out;
   logic         core_data_out_valid;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  in_data;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [63:0]  out_data;
   logic         out_last;
   logic         busy;
   logic         done;
   logic [15:0]  blocks_used;

   chacha_stream_xor dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .start               (start),
      .core_init           (core_init),
      .core_next           (core_next),
      .core_ready          (core_ready),
      .core_data_out       (core_data_out),
      .core_data_out_valid (core_data_out_valid),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_data             (in_data),
      .in_last             (in_last),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_data            (out_data),
      .out_last            (out_last),
      .busy                (busy),
      .done                (done),
      .blocks_used         (blocks_used)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          nwords;
      logic [63:0] pat;
      int          exp_blocks;
      int          exp_next;
   } vec_t;

   localparam logic [511:0] STALE = {8{64'hA5A5_5A5A_C3C3_3C3C}};

   vec_t        vecs[5];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_init   = 0;
   int          n_next   = 0;
   int          n_both   = 0;
   int          n_done   = 0;
   int          lat      = 0;
   logic [64:0] exp_q[$];
   logic [64:0] mon_e;

   function automatic logic [63:0] ks_word(input int k);
      return 64'h1111_1111_1111_1111 * 64'(k + 1);
   endfunction

   function automatic logic [511:0] ks_block();
      logic [511:0] b;
      b = 512'd0;
      for (int k = 0; k < 8; k++) b[511 - 64*k -: 64] = ks_word(k);
      return b;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // chacha_core model: stale valid held through the pulse cycle, fresh block 4 cycles later.
   always @(negedge clk) begin
      if (!reset_n) begin
         lat                 = 0;
         core_data_out       = 512'd0;
         core_data_out_valid = 1'b0;
      end else if (core_init || core_next) begin
         if (core_init) n_init++;
         if (core_next) n_next++;
         if (core_init && core_next) n_both++;
         core_data_out       = STALE;
         core_data_out_valid = 1'b1;
         lat                 = 4;
      end else if (lat > 0) begin
         lat = lat - 1;
         if (lat == 3) core_data_out_valid = 1'b0;
         if (lat == 0) begin
            core_data_out       = ks_block();
            core_data_out_valid = 1'b1;
         end
      end
   end

   // Output monitor: compares every drained word against the expected queue.
   always @(negedge clk) begin
      if (reset_n) begin
         if (done) n_done++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 64'(out_valid), 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("out_data", out_data, mon_e[64:1]);
               check("out_last", 64'(out_last), 64'(mon_e[0]));
            end
         end
      end
   end

   task automatic send_word(input logic [63:0] d, input logic last, input int k);
      int t;
      t        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check("in_ready_timeout", 64'd0, 64'd1);
      else exp_q.push_back({d ^ ks_word(k % 8), last});
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic run_msg(input string nm, input int n, input logic [63:0] pat,
                          input int exp_blocks, input int exp_next);
      int i0, x0, d0, t;
      i0 = n_init;
      x0 = n_next;
      d0 = n_done;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({nm, "_busy"}, 64'(busy), 64'd1);
      for (int k = 0; k < n; k++) send_word(pat, (k == n - 1), k);
      t = 0;
      while ((busy || exp_q.size() != 0) && t < 100) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      check({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
      check({nm, "_idle"}, 64'(busy), 64'd0);
      check({nm, "_blocks_used"}, 64'(blocks_used), 64'(exp_blocks));
      check({nm, "_init_pulses"}, 64'(n_init - i0), 64'd1);
      check({nm, "_next_pulses"}, 64'(n_next - x0), 64'(exp_next));
      check({nm, "_done_pulses"}, 64'(n_done - d0), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{"single",    1, 64'h0000_0000_0000_0000, 1, 0};
      vecs[1] = '{"eight",     8, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0};
      vecs[2] = '{"nine",      9, 64'h0123_4567_89AB_CDEF, 2, 1};
      vecs[3] = '{"sixteen",  16, 64'hA5A5_A5A5_A5A5_A5A5, 2, 1};
      vecs[4] = '{"seventeen",17, 64'h0F0F_F0F0_1234_8765, 3, 2};

      reset_n    = 1'b0;
      start      = 1'b0;
      core_ready = 1'b1;
      in_valid   = 1'b0;
      in_data    = 64'd0;
      in_last    = 1'b0;
      out_ready  = 1'b1;
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_data", out_data, 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd0);
      check("reset_blocks_used", 64'(blocks_used), 64'd0);
      check("reset_core_pulses", 64'({core_init, core_next, done}), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 5; v++)
         run_msg(vecs[v].name, vecs[v].nwords, vecs[v].pat, vecs[v].exp_blocks, vecs[v].exp_next);

      // Output back-pressure for 5 cycles in the middle of a message.
      fork
         run_msg("stall", 6, 64'h7777_0000_FFFF_1234, 1, 0);
         begin
            int t;
            t = 0;
            while (!out_valid && t < 100) begin
               @(negedge clk);
               t++;
            end
            @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check("stall_in_ready", 64'(in_ready), 64'd0);
               check("stall_out_valid", 64'(out_valid), 64'd1);
               check("stall_out_data", out_data, exp_q[0][64:1]);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join

      // Reset in the middle of STREAM with idx=3.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 3; k++) send_word(64'h5555_5555_5555_5555, 1'b0, k);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_out_data", out_data, 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      check("midrst_blocks_used", 64'(blocks_used), 64'd0);
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check("midrst_stays_idle", 64'(busy), 64'd0);
      run_msg("after_reset", 2, 64'hCAFE_F00D_DEAD_BEEF, 1, 0);

      check("init_next_overlap", 64'(n_both), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/chacha_stream_xor.md
CHACHA_STREAM_XOR -- requirements
Module: chacha_stream_xor

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, one-cycle request to begin a message; ignored unless state is IDLE.
REQ-004 SHALL have port core_init, output, 1, one-cycle pulse to chacha_core init (first block).
REQ-005 SHALL have port core_next, output, 1, one-cycle pulse to chacha_core next (following blocks).
REQ-006 SHALL have port core_ready, input, 1, chacha_core ready.
REQ-007 SHALL have port core_data_out, input, 512, keystream block from chacha_core.
REQ-008 SHALL have port core_data_out_valid, input, 1, keystream block valid.
REQ-009 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, 64) and in_last (input, 1), forming the plaintext stream.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 64) and out_last (output, 1), forming the ciphertext stream.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when the last word is accepted.
REQ-013 SHALL have port blocks_used, output, 16, count of keystream blocks requested in the current or last message.

Function
REQ-014 SHALL use the states IDLE, REQ, WAIT and STREAM.
REQ-015 IDLE -> REQ on start; SHALL clear blocks_used to 0 and set first_flag to 1.
REQ-016 REQ: SHALL wait for core_ready=1, then pulse exactly one cycle on core_init if first_flag=1, else on core_next; SHALL clear first_flag, increment blocks_used (wrap at 16'hFFFF -> 0) and go to WAIT.
REQ-017 WAIT: SHALL ignore core_data_out_valid in the first cycle after the pulse (guard against a stale valid).
REQ-018 WAIT, from the second cycle on: SHALL latch core_data_out into a 512-bit buffer, set word index idx=0 and go to STREAM when core_ready=1 and core_data_out_valid=1.
REQ-019 Word order: word k SHALL be buffer[511-64k -: 64], so word 0 is the MSB 64 bits.
REQ-020 SHALL drive in_ready = (state==STREAM) AND (out_valid=0 OR out_ready=1), purely combinationally.
REQ-021 Input transfer (in_valid AND in_ready) SHALL register out_data = in_data XOR word[idx], out_last = in_last and out_valid=1, giving 1-cycle latency.
REQ-022 Output transfer (out_valid AND out_ready) with no new input transfer SHALL clear out_valid; a simultaneous input transfer SHALL keep out_valid=1 and load the new word, for full throughput.
REQ-023 SHALL increment idx (3 bits) on each input transfer; a transfer at idx=7 with in_last=0 SHALL go to REQ and lower in_ready for the refill.
REQ-024 An input transfer with in_last=1 at any idx SHALL go to IDLE, pulse done in the same cycle, issue no core_next and discard the remaining keystream.
REQ-025 SHALL hold out_valid, out_data and out_last stable while out_valid=1 and out_ready=0, including across REQ/WAIT, so a pending output drains independently of state.
REQ-026 start outside IDLE SHALL be ignored; in_valid outside STREAM SHALL be ignored (in_ready=0).
REQ-027 core_init and core_next SHALL never be high in the same cycle and SHALL never be high for more than one cycle.

Reset
REQ-028 reset_n=0 SHALL asynchronously force: state IDLE, core_init=0, core_next=0, in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, blocks_used=0, idx=0, buffer=0, first_flag=1.
REQ-029 Reset asserted mid-message SHALL abort the message; after release the block SHALL stay idle until a new start.

Verification
REQ-030 The bench SHALL cover these scenarios, using a core model returning keystream word k = 64'h1111111111111111*(k+1), block-independent:
- Single word: start, in_data=64'h0, in_last=1 -> one core_init, out_data=64'h1111111111111111, out_last=1, done pulse, blocks_used=1.
- 8 words of 64'hFFFFFFFFFFFFFFFF with last on word 7 -> outputs ~word k in order, no core_next, blocks_used=1.
- 9 words -> exactly one core_next after word 7; word 8 = data XOR 64'h1111111111111111; blocks_used=2.
- out_ready held 0 for 5 cycles mid-stream -> in_ready=0, out_data stable, no word lost or duplicated.
- Stale core_data_out_valid=1 held through the pulse cycle -> no latch until the guard cycle passes.
- reset_n low during STREAM at idx=3 -> all outputs go to reset values at once; a new start then issues core_init (not core_next).
